// File: rtl/gtech_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_t : FSM state encoding (IDLE / HOLD)
//   thermo      : thermometer mask with bits 0..idx set (limited to n bits)
//   lsb_onehot  : isolates the lowest set bit of a vector
//   onehot2idx  : binary index of a one-hot vector
// All helpers work on MAX_N-bit vectors; callers zero-extend / truncate.
package gtech_arb_pkg;

  localparam int unsigned MAX_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  function automatic logic [MAX_N-1:0] thermo(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if ((k <= idx) && (k < n)) t[k] = 1'b1;
    end
    return t;
  endfunction

  // Two's-complement trick: vec & -vec keeps only the lowest set bit.
  function automatic logic [MAX_N-1:0] lsb_onehot(input logic [MAX_N-1:0] vec);
    return vec & (~vec + MAX_N'(1));
  endfunction

  function automatic logic [3:0] onehot2idx(input logic [MAX_N-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (vec[k]) idx = idx | 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gtech_rr_arbiter_rr_pick.sv
// Combinational round-robin winner picker.
//   req     : request vector
//   last    : index of the most recent grant (priority pointer)
//   excl    : requesters to leave out of this arbitration
//   win_oh  : one-hot winner (zero when nothing eligible)
//   win_idx : binary index of the winner
//   win_vld : at least one eligible requester
// Candidates strictly above last win first (AND-NOT with a thermometer of
// last); if none exist the search wraps to the lowest eligible bit.
module rr_pick
  import gtech_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  logic [MAX_N-1:0] cand;
  logic [MAX_N-1:0] above;
  logic [MAX_N-1:0] pick;

  always_comb begin
    cand        = '0;
    cand[N-1:0] = req & ~excl;
    above       = cand & ~thermo(int'(last), N);
    pick        = (above != '0) ? lsb_onehot(above) : lsb_onehot(cand);
  end

  assign win_oh  = pick[N-1:0];
  assign win_idx = IW'(onehot2idx(pick));
  assign win_vld = |cand;

  // Bits above N are always zero; tie them off so they read as intentional.
  if (N < MAX_N) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^pick[MAX_N-1:N];
  end

endmodule

// File: rtl/gtech_rr_arbiter.sv
// Round-robin arbiter with hold-until-release and optional hold timeout.
//   CP        : clock, rising edge
//   CD        : asynchronous active-low reset
//   REQ[N]    : request vector
//   GNT[N]    : registered one-hot (or zero) grant
//   GNT_IDX   : binary index of the owner, meaningful while BUSY
//   BUSY      : resource owned (OR of GNT)
//   TIMEOUT   : one-cycle pulse in the cycle after a forced release
//   state_dbg : current FSM state
// Handshake: a requester raises REQ and keeps it high for as long as it wants
// or uses the resource; GNT follows one edge later and stays up until the
// edge that samples REQ low (or the hold limit). The owner's GNT is still high
// in the cycle it drops REQ, so the resource must qualify use with REQ & GNT.
module gtech_rr_arbiter
  import gtech_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(N)
) (
  input  logic          CP,
  input  logic          CD,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] GNT_IDX,
  output logic          BUSY,
  output logic          TIMEOUT,
  output arb_state_t    state_dbg
);

  localparam int            CW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic          own_req;
  logic          hold_limit;
  logic          forced;
  logic [N-1:0]  excl;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          win_vld;

  assign own_req    = REQ[idx_q];
  assign hold_limit = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);
  assign forced     = (state_q == HOLD) && own_req && hold_limit;
  // On a forced release the current owner sits out this arbitration.
  assign excl       = forced ? gnt_q : '0;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (REQ),
    .last    (last_q),
    .excl    (excl),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // State and output registers.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = HOLD;
          gnt_d   = win_oh;
          idx_d   = win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!own_req) begin
          if (win_vld) begin
            gnt_d  = win_oh;
            idx_d  = win_idx;
            last_d = win_idx;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (hold_limit) begin
          to_d  = 1'b1;
          cnt_d = '0;
          if (win_vld) begin
            gnt_d  = win_oh;
            idx_d  = win_idx;
            last_d = win_idx;
          end else begin
            // Nobody else waiting: re-grant the same owner.
            last_d = idx_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    GNT       = gnt_q;
    GNT_IDX   = idx_q;
    BUSY      = |gnt_q;
    TIMEOUT   = to_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_gtech_rr_arbiter.sv
module tb_gtech_rr_arbiter;
  import gtech_arb_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IW       = 2;
  localparam int EW       = N + IW + 2;

  // ---------------- clock / reset ----------------
  logic          CP = 1'b0;
  logic          CD = 1'b0;
  logic [N-1:0]  REQ = '0;
  logic [N-1:0]  GNT;
  logic [IW-1:0] GNT_IDX;
  logic          BUSY;
  logic          TIMEOUT;
  arb_state_t    state_dbg;

  always #5 CP = ~CP;

  gtech_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .IW       (IW)
  ) dut (
    .CP        (CP),
    .CD        (CD),
    .REQ       (REQ),
    .GNT       (GNT),
    .GNT_IDX   (GNT_IDX),
    .BUSY      (BUSY),
    .TIMEOUT   (TIMEOUT),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Priority is a circular search starting just after the last grant.
  int m_last, m_owner, m_cnt;
  bit m_busy;

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = 0;
    m_cnt   = 0;
    m_busy  = 0;
  endtask

  function automatic int rr_find(input logic [N-1:0] req, input int skip);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_busy  = 1;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req);
    bit            to;
    int            w;
    logic [N-1:0]  g;
    logic [IW-1:0] ix;
    to = 0;
    if (!m_busy) begin
      w = rr_find(req, -1);
      if (w >= 0) model_grant(w);
    end else if (!req[m_owner]) begin
      w = rr_find(req, -1);
      if (w >= 0) model_grant(w);
      else m_busy = 0;
    end else if (m_cnt == MAX_HOLD - 1) begin
      to = 1;
      w  = rr_find(req, m_owner);
      if (w < 0) w = m_owner;
      model_grant(w);
    end else begin
      m_cnt++;
    end
    g  = m_busy ? N'(1 << m_owner) : '0;
    ix = IW'(m_owner);
    exp_q.push_back({g, ix, m_busy, to});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [N-1:0] r);
    @(negedge CP);
    REQ = r;
    model_step(r);
  endtask

  task automatic release_reset(input logic [N-1:0] r);
    @(negedge CP);
    CD  = 1'b1;
    REQ = r;
    model_step(r);
  endtask

  // Asserted just after the monitor has consumed the last expectation.
  task automatic mid_reset(input logic [N-1:0] r_after);
    @(posedge CP);
    #3;
    CD = 1'b0;
    #1;
    check("async_rst_gnt", 32'(GNT), 32'(0));
    check("async_rst_busy", 32'(BUSY), 32'(0));
    check("async_rst_to", 32'(TIMEOUT), 32'(0));
    model_reset();
    @(posedge CP);
    #2;
    check("rst_hold_gnt", 32'(GNT), 32'(0));
    release_reset(r_after);
  endtask

  // ---------------- monitor ----------------
  always @(posedge CP) begin
    logic [EW-1:0] e;
    logic [N-1:0]  eg;
    logic [IW-1:0] ei;
    logic          eb, et;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {eg, ei, eb, et} = e;
      check("gnt", 32'(GNT), 32'(eg));
      check("busy", 32'(BUSY), 32'(eb));
      check("timeout", 32'(TIMEOUT), 32'(et));
      if (eb) check("gnt_idx", 32'(GNT_IDX), 32'(ei));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] r;
    model_reset();
    CD  = 1'b0;
    REQ = 4'b1111;
    #12;
    check("rst_gnt", 32'(GNT), 32'(0));
    check("rst_idx", 32'(GNT_IDX), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_to", 32'(TIMEOUT), 32'(0));
    #15;
    check("rst_gnt_edge", 32'(GNT), 32'(0));
    release_reset(4'b1111);

    // Rotation 0,1,2,3,0,1 with one-cycle drops.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111);
      cycle(4'b1111 & ~N'(1 << m_owner));
    end

    // Masking wrap: LAST=2, REQ=0011 -> requester 0.
    cycle(4'b0000);
    cycle(4'b0100);
    cycle(4'b0011);
    cycle(4'b0000);

    // Timeout handover to 3, then lone-owner re-grant.
    cycle(4'b0010);
    repeat (6) cycle(4'b1010);
    repeat (6) cycle(4'b0010);

    // Release to idle, then LAST+1 wins.
    cycle(4'b0000);
    cycle(4'b1111);

    // Reset while requester 2 owns the resource.
    mid_reset(4'b0100);
    cycle(4'b0100);

    // Randomized traffic with persistent requests.
    r = 4'b0100;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) r = N'($urandom_range(0, 15));
      else begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      if (i == 200) mid_reset(r);
      else cycle(r);
    end

    cycle(4'b0000);
    repeat (3) @(negedge CP);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
